// File: rtl/regfile_pkg.sv
// Shared types and helpers for the bank-switched index register file.
// Optional feature macro used by the top: REGFILE_PARITY_EN.
package regfile_pkg;

  // FIN fetch sequencer states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADDR   = 2'd1,
    CAP_HI = 2'd2
  } fin_state_t;

  // Program counter width for a given nibble width.
  function automatic int unsigned pc_w(input int unsigned data_w);
    return 3 * data_w;
  endfunction

  // Register-pair width for a given nibble width.
  function automatic int unsigned pair_w(input int unsigned data_w);
    return 2 * data_w;
  endfunction

  // Bank select width; at least one bit so the port always exists.
  function automatic int unsigned bank_w(input int unsigned num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 1;
  endfunction

  // Logical index + bank -> physical register slot.
  function automatic int unsigned phys_idx(input int unsigned idx,
                                           input int unsigned bank,
                                           input int unsigned num_regs,
                                           input int unsigned banked_regs);
    if (bank == 0 || idx >= banked_regs) return idx;
    return num_regs + (bank - 1) * banked_regs + idx;
  endfunction

endpackage

// File: rtl/regfile_fin_seq.sv
// FIN fetch sequencer: walks IDLE -> ADDR -> CAP_HI, raises the capture
// enables for the even/odd register of the destination pair and selects
// the ROM address nibble (pair 0 during FIN, program counter otherwise).
module regfile_fin_seq
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      fin,
  input  logic                      a1,
  input  logic                      a2,
  input  logic                      a3,
  input  logic                      m1,
  input  logic                      m2,
  input  logic [DATA_W-1:0]         r0,
  input  logic [DATA_W-1:0]         r1,
  input  logic [pc_w(DATA_W)-1:0]   pc,
  input  logic [DATA_W-1:0]         ppo_hi,
  output logic                      cap_even,
  output logic                      cap_odd,
  output logic                      fin_busy,
  output logic [DATA_W-1:0]         rom_addr,
  output fin_state_t                state
);

  fin_state_t state_q, state_d;
  logic       fin_busy_q;
  logic       fin_mode;

  // Next state and capture enables; dropping fin aborts without writing.
  always_comb begin
    state_d  = state_q;
    cap_even = 1'b0;
    cap_odd  = 1'b0;
    unique case (state_q)
      IDLE:   if (fin && a1) state_d = ADDR;
      ADDR: begin
        if (!fin) state_d = IDLE;
        else if (m1) begin
          state_d  = CAP_HI;
          cap_even = 1'b1;
        end
      end
      CAP_HI: begin
        if (!fin) state_d = IDLE;
        else if (m2) begin
          state_d = IDLE;
          cap_odd = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with registered busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fin_busy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fin_busy_q <= (state_d != IDLE);
    end
  end

  // The address phase of a FIN starts in IDLE with the A1 strobe, so the
  // pair-0 bus mode already covers that first cycle.
  assign fin_mode = (state_q == ADDR) || (state_q == IDLE && fin);

  // ROM address nibble select by strobe.
  always_comb begin
    rom_addr = '0;
    if (fin_mode) begin
      if (a1)      rom_addr = r1;
      else if (a2) rom_addr = r0;
      else if (a3) rom_addr = ppo_hi;
    end else begin
      if (a1)      rom_addr = pc[DATA_W-1:0];
      else if (a2) rom_addr = pc[2*DATA_W-1:DATA_W];
      else if (a3) rom_addr = pc[3*DATA_W-1:2*DATA_W];
    end
  end

  assign fin_busy = fin_busy_q;
  assign state    = state_q;

endmodule

// File: rtl/idx_regfile_banked.sv
// Bank-switched index register file (4040-style) with FIN fetch sequencer.
// Define REGFILE_PARITY_EN to store an even-parity bit per physical register
// and flag read-side mismatches on par_err.
module idx_regfile_banked
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W      = 4,
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned NUM_BANKS   = 2,
  parameter int unsigned BANKED_REGS = 8
) (
  input  logic                          CLK,
  input  logic                          RES_N,
  input  logic                          A1,
  input  logic                          A2,
  input  logic                          A3,
  input  logic                          M1,
  input  logic                          M2,
  input  logic [DATA_W-1:0]             DATA_I,
  input  logic [pc_w(DATA_W)-1:0]       pc,
  input  logic [pc_w(DATA_W)-1:0]       pc_plus_one,
  input  logic [DATA_W:0]               alu,
  input  logic [DATA_W-1:0]             acc,
  input  logic [$clog2(NUM_REGS)-1:0]   reg_idx,
  input  logic [pair_w(DATA_W)-1:0]     imm,
  input  logic                          rp_fim,
  input  logic                          fin,
  input  logic                          rn_alu,
  input  logic                          rn_acc,
  input  logic                          sb_req,
  input  logic [bank_w(NUM_BANKS)-1:0]  sb_bank,
  output logic [DATA_W-1:0]             rn,
  output logic                          rn_zero,
  output logic [pair_w(DATA_W)-1:0]     rp,
  output logic [DATA_W-1:0]             rom_addr_o,
  output logic                          fin_busy,
  output logic [bank_w(NUM_BANKS)-1:0]  bank_o,
  output logic                          par_err,
  input  logic                          par_err_clr
);

  localparam int unsigned AW   = $clog2(NUM_REGS);
  localparam int unsigned BW   = bank_w(NUM_BANKS);
  localparam int unsigned PHYS = NUM_REGS + (NUM_BANKS - 1) * BANKED_REGS;
  localparam int unsigned PW   = $clog2(PHYS);

  function automatic logic [PW-1:0] map_idx(input logic [AW-1:0] idx,
                                            input logic [BW-1:0] bank);
    return PW'(phys_idx(32'(idx), 32'(bank), NUM_REGS, BANKED_REGS));
  endfunction

  logic [DATA_W-1:0] regs_q [PHYS];
  logic [DATA_W-1:0] regs_d [PHYS];
  logic [BW-1:0]     bank_q, bank_d, pend_bank_q, pend_bank_d;
  logic              pend_vld_q, pend_vld_d;
  logic [AW-1:0]     even_idx, odd_idx;
  logic [PW-1:0]     rn_phys, wa0, wa1;
  logic [DATA_W-1:0] wd0, wd1;
  logic              we0, we1;
  logic              cap_even, cap_odd;
  fin_state_t        fin_state;
  logic              unused_inputs;

  assign even_idx = {reg_idx[AW-1:1], 1'b0};
  assign odd_idx  = {reg_idx[AW-1:1], 1'b1};
  assign rn_phys  = map_idx(reg_idx, bank_q);

  // Reads see the current bank and the registered contents only.
  assign rn      = regs_q[rn_phys];
  assign rn_zero = (rn == '0);
  assign rp      = {regs_q[map_idx(even_idx, bank_q)], regs_q[map_idx(odd_idx, bank_q)]};
  assign bank_o  = bank_q;

  regfile_fin_seq #(.DATA_W(DATA_W)) u_fin_seq (
    .clk      (CLK),
    .rst_n    (RES_N),
    .fin      (fin),
    .a1       (A1),
    .a2       (A2),
    .a3       (A3),
    .m1       (M1),
    .m2       (M2),
    .r0       (regs_q[map_idx(AW'(0), bank_q)]),
    .r1       (regs_q[map_idx(AW'(1), bank_q)]),
    .pc       (pc),
    .ppo_hi   (pc_plus_one[3*DATA_W-1:2*DATA_W]),
    .cap_even (cap_even),
    .cap_odd  (cap_odd),
    .fin_busy (fin_busy),
    .rom_addr (rom_addr_o),
    .state    (fin_state)
  );

  // Single prioritised write source per edge; FIM is the only two-register write.
  always_comb begin
    we0 = 1'b0;
    we1 = 1'b0;
    wa0 = '0;
    wa1 = '0;
    wd0 = '0;
    wd1 = '0;
    if (rp_fim) begin
      we0 = 1'b1;
      wa0 = map_idx(even_idx, bank_q);
      wd0 = imm[2*DATA_W-1:DATA_W];
      we1 = 1'b1;
      wa1 = map_idx(odd_idx, bank_q);
      wd1 = imm[DATA_W-1:0];
    end else if (cap_even) begin
      we0 = 1'b1;
      wa0 = map_idx(even_idx, bank_q);
      wd0 = DATA_I;
    end else if (cap_odd) begin
      we0 = 1'b1;
      wa0 = map_idx(odd_idx, bank_q);
      wd0 = DATA_I;
    end else if (rn_alu) begin
      we0 = 1'b1;
      wa0 = rn_phys;
      wd0 = alu[DATA_W-1:0];
    end else if (rn_acc) begin
      we0 = 1'b1;
      wa0 = rn_phys;
      wd0 = acc;
    end
  end

  // Next register contents from the selected write.
  always_comb begin
    regs_d = regs_q;
    if (we0) regs_d[wa0] = wd0;
    if (we1) regs_d[wa1] = wd1;
  end

  // Bank switch: immediate when the sequencer is idle, otherwise parked
  // until it has returned to IDLE; a newer request replaces a parked one.
  always_comb begin
    bank_d      = bank_q;
    pend_vld_d  = pend_vld_q;
    pend_bank_d = pend_bank_q;
    if (NUM_BANKS > 1) begin
      if (sb_req && (32'(sb_bank) < NUM_BANKS)) begin
        if (fin_state == IDLE) begin
          bank_d     = sb_bank;
          pend_vld_d = 1'b0;
        end else begin
          pend_vld_d  = 1'b1;
          pend_bank_d = sb_bank;
        end
      end else if (pend_vld_q && fin_state == IDLE) begin
        bank_d     = pend_bank_q;
        pend_vld_d = 1'b0;
      end
    end
  end

  // Storage and bank state.
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      regs_q      <= '{default: '0};
      bank_q      <= '0;
      pend_vld_q  <= 1'b0;
      pend_bank_q <= '0;
    end else begin
      regs_q      <= regs_d;
      bank_q      <= bank_d;
      pend_vld_q  <= pend_vld_d;
      pend_bank_q <= pend_bank_d;
    end
  end

`ifdef REGFILE_PARITY_EN
  logic [PHYS-1:0] par_q, par_d;
  logic            par_err_q, par_err_d, par_bad;

  // Parity bits follow every register write.
  always_comb begin
    par_d = par_q;
    if (we0) par_d[wa0] = ^wd0;
    if (we1) par_d[wa1] = ^wd1;
  end

  assign par_bad = (A1 | A2 | A3 | M1 | M2) && ((^rn) != par_q[rn_phys]);

  // Sticky error: a new mismatch outranks a same-cycle clear.
  always_comb begin
    par_err_d = par_err_q;
    if (par_bad)          par_err_d = 1'b1;
    else if (par_err_clr) par_err_d = 1'b0;
  end

  // Parity storage and error flag.
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      par_q     <= '0;
      par_err_q <= 1'b0;
    end else begin
      par_q     <= par_d;
      par_err_q <= par_err_d;
    end
  end

  assign par_err       = par_err_q;
  assign unused_inputs = ^{alu[DATA_W], pc_plus_one[2*DATA_W-1:0]};
`else
  assign par_err       = 1'b0;
  assign unused_inputs = ^{alu[DATA_W], pc_plus_one[2*DATA_W-1:0], par_err_clr};
`endif

endmodule
